la_dump_seq: RTL and testbench
==============================

# la_dump_seq

Sequences a channel dump from the logic analyzer's capture RAM to the host UART transmitter. On a dump request from the command processor it walks the circular capture buffer, starting at the oldest sample and wrapping around. Each RAM byte is handed to the UART transmitter under a trmt/tx_done handshake. It sits between the command decoder, the capture RAM read port and UART_tx inside LA_dig.

## Interface
- ENTRIES, 384: capture depth in samples per channel.
- ADDR_W, 9: RAM address width; ENTRIES ≤ 2^ADDR_W.
- NUM_CH, 5: number of valid channels, numbered 1..NUM_CH.
- NAK_BYTE, 8'hEE: byte sent in place of a dump for an invalid channel.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- dump_req  in  1  one-cycle pulse from the command decoder; sampled only in IDLE.
- dump_ch  in  3  channel to dump; sampled with dump_req.
- trig_pos  in  ADDR_W  address of the oldest sample; stable while busy.
- ram_ch  out  3  channel select to the RAM read mux; holds the latched dump_ch.
- ram_addr  out  ADDR_W  read address.
- ram_rd_en  out  1  read strobe.
- ram_rdata  in  8  read data, valid exactly one cycle after ram_rd_en.
- tx_data  out  8  byte to UART_tx.
- trmt  out  1  one-cycle transmit start.
- tx_done  in  1  UART_tx finished the byte.
- busy  out  1  high from the cycle after an accepted dump_req until the return to IDLE.

## Operation
- States: IDLE, RD, LAT, TX, WAIT, NAK.
- IDLE, dump_req with dump_ch in 1..NUM_CH:
  - Latch the channel; load the address with trig_pos and the count with 0.
  - Go to RD.
- IDLE, dump_req with dump_ch = 0 or > NUM_CH: load tx_data = NAK_BYTE and go to NAK.
- RD: ram_rd_en = 1; go to LAT.
- LAT: tx_data <= ram_rdata; go to TX.
- TX: trmt = 1 for this cycle only; go to WAIT.
- WAIT, on tx_done:
  - If count == ENTRIES-1, go to IDLE.
  - Otherwise increment the count, advance the address, and go to RD.
- Address wraps: ENTRIES-1 -> 0 (not 2^ADDR_W-1 -> 0).
- NAK: trmt = 1 for one cycle, then wait for tx_done, then go to IDLE.
- Exactly ENTRIES bytes are sent per valid dump, oldest sample first.
- dump_req while busy is ignored and not queued.
- tx_done is ignored outside WAIT and NAK-wait.
- A tx_done in the same cycle as trmt is not counted.

## Timing
- Reset values: state IDLE; ram_addr 0; ram_ch 0; ram_rd_en 0; tx_data 8'h00; trmt 0; busy 0; count 0.
- From dump_req to the first trmt: 3 cycles (RD, LAT, TX).
- From tx_done to the next trmt: 3 cycles.
- Per byte: 3 cycles plus the UART byte time.
- rst mid-dump: returns to IDLE on the next edge with trmt and ram_rd_en low. A byte already in UART_tx completes on its own; no further bytes are issued.

## Configuration
- Macro DUMP_CHKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of all dumped bytes is kept.
  - After the last sample byte's tx_done, state CHK sends the sum as byte ENTRIES+1, then goes to IDLE.
  - NAK sends no checksum.
- Undefined: no sum register and no CHK state; exactly ENTRIES bytes are sent.

## Structure
- The shared package la_pkg holds:
  - The state enum.
  - NAK_BYTE.
  - The channel-number constants CH1..CH5, which the command decoder and testbench also use.
- One sub-module: la_circ_addr.
  - Loadable address counter with wrap at ENTRIES-1, plus a terminal-count flag.
  - Reusable by the capture write side.

## Test plan
- rst, then idle 10 cycles -> all outputs hold their reset values and busy = 0.
- dump_req, dump_ch = 3, trig_pos = 100, RAM[a] = a[7:0], tx_done returned 20 cycles after each trmt:
  - 384 trmt pulses; the first byte is 8'h64.
  - The address sequence is 100..383, then 0..99.
  - busy falls after the last tx_done.
- dump_ch = 0, and separately dump_ch = 7 -> a single trmt with tx_data = 8'hEE; ram_rd_en never asserts.
- dump_req pulsed again mid-dump -> ignored; the byte count stays 384.
- rst asserted after the 50th trmt -> IDLE next cycle, no further trmt; a new dump_req then starts cleanly at trig_pos.
- With DUMP_CHKSUM_EN and RAM[a] = 1 for all addresses -> 385 bytes; the final byte is 384 mod 256 = 8'h80.

Source files
------------

// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: dump sequencer states, NAK byte and
// channel numbers used by the command decoder and the dump path.
// DUMP_CHKSUM_EN adds the CHK state for the trailing checksum byte.
package la_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LAT,
    TX,
    WAIT,
    NAK
`ifdef DUMP_CHKSUM_EN
    ,
    CHK
`endif
  } la_state_t;

  localparam logic [7:0] NAK_BYTE = 8'hEE;

  localparam logic [2:0] CH1 = 3'd1;
  localparam logic [2:0] CH2 = 3'd2;
  localparam logic [2:0] CH3 = 3'd3;
  localparam logic [2:0] CH4 = 3'd4;
  localparam logic [2:0] CH5 = 3'd5;

endpackage

// File: rtl/la_circ_addr.sv
// Loadable circular counter over 0..ENTRIES-1 with a terminal-count flag.
// Used for both the read address and the byte count of a dump; also
// suitable for the capture write pointer.
module la_circ_addr #(
  parameter int ENTRIES = 384,
  parameter int ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);

  // wrap is at ENTRIES-1, not at the power-of-two boundary
  assign tc = (addr == ADDR_W'(ENTRIES - 1));

  // load has priority over advance
  always_ff @(posedge clk) begin
    if (rst)       addr <= '0;
    else if (load) addr <= load_val;
    else if (adv)  addr <= tc ? '0 : addr + 1'b1;
  end

endmodule

// File: rtl/la_dump_seq.sv
// Channel dump sequencer: walks the circular capture buffer from the oldest
// sample and hands each byte to UART_tx under a trmt/tx_done handshake.
// Invalid channels get a single NAK byte.
// DUMP_CHKSUM_EN: append an 8-bit running sum after the last sample byte.
module la_dump_seq
  import la_pkg::*;
#(
  parameter int ENTRIES = 384,
  parameter int ADDR_W  = 9,
  parameter int NUM_CH  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_req,
  input  logic [2:0]        dump_ch,
  input  logic [ADDR_W-1:0] trig_pos,
  output logic [2:0]        ram_ch,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        tx_data,
  output logic              trmt,
  input  logic              tx_done,
  output logic              busy
);

  la_state_t         state, nxt;
  logic              ld, adv, cnt_tc, last_byte, ch_ok;
  logic [ADDR_W-1:0] cnt;
`ifdef DUMP_CHKSUM_EN
  logic [7:0]        sum;
`endif

  assign ch_ok = (dump_ch != 3'd0) && (32'(dump_ch) <= NUM_CH);
  assign busy  = (state != IDLE);

  la_circ_addr #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) u_addr (
    .clk(clk), .rst(rst), .load(ld), .load_val(trig_pos), .adv(adv),
    .addr(ram_addr), .tc()
  );

  // byte counter shares the wrap logic; its terminal count ends the dump
  la_circ_addr #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) u_cnt (
    .clk(clk), .rst(rst), .load(ld), .load_val('0), .adv(adv),
    .addr(cnt), .tc(cnt_tc)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next state and strobes; tx_done only matters in WAIT, which always
  // follows the trmt cycle, so a tx_done coincident with trmt is dropped
  always_comb begin
    nxt       = state;
    ram_rd_en = 1'b0;
    trmt      = 1'b0;
    ld        = 1'b0;
    adv       = 1'b0;
    case (state)
      IDLE: if (dump_req) begin
        ld  = ch_ok;
        nxt = ch_ok ? RD : NAK;
      end
      RD: begin
        ram_rd_en = 1'b1;
        nxt       = LAT;
      end
      LAT: nxt = TX;
      TX: begin
        trmt = 1'b1;
        nxt  = WAIT;
      end
      NAK: begin
        trmt = 1'b1;
        nxt  = WAIT;
      end
      WAIT: if (tx_done) begin
        if (last_byte) nxt = IDLE;
`ifdef DUMP_CHKSUM_EN
        else if (cnt_tc) nxt = CHK;
`else
        else if (cnt_tc) nxt = IDLE;
`endif
        else begin
          adv = 1'b1;
          nxt = RD;
        end
      end
`ifdef DUMP_CHKSUM_EN
      CHK: nxt = TX;
`endif
      default: nxt = IDLE;
    endcase
  end

  // datapath: channel latch, transmit byte, final-byte flag, checksum
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_ch    <= 3'd0;
      tx_data   <= 8'h00;
      last_byte <= 1'b0;
`ifdef DUMP_CHKSUM_EN
      sum       <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: if (dump_req) begin
          if (ch_ok) begin
            ram_ch    <= dump_ch;
            last_byte <= 1'b0;
`ifdef DUMP_CHKSUM_EN
            sum       <= 8'h00;
`endif
          end else begin
            tx_data   <= NAK_BYTE;
            last_byte <= 1'b1;
          end
        end
        LAT: begin
          tx_data <= ram_rdata;
`ifdef DUMP_CHKSUM_EN
          sum     <= sum + ram_rdata;
`endif
        end
`ifdef DUMP_CHKSUM_EN
        CHK: begin
          tx_data   <= sum;
          last_byte <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_la_dump_seq.sv
// Scoreboard bench for la_dump_seq: stimulus pushes expected bytes and
// read addresses; a monitor pops and compares on every trmt / ram_rd_en.
module tb_la_dump_seq;
  import la_pkg::*;

  localparam int ENTRIES = 384;
  localparam int ADDR_W  = 9;
  localparam int NUM_CH  = 5;
  localparam int TX_LAT  = 20;
  localparam int BUDGET  = 20000;
`ifdef DUMP_CHKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              dump_req;
  logic [2:0]        dump_ch;
  logic [ADDR_W-1:0] trig_pos;
  logic [2:0]        ram_ch;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd_en;
  logic [7:0]        ram_rdata = 8'h00;
  logic [7:0]        tx_data;
  logic              trmt;
  logic              tx_done = 1'b0;
  logic              busy;

  logic [7:0]        exp_byte[$];
  logic [ADDR_W-1:0] exp_addr[$];
  int                n_cmp = 0;
  int                n_bad = 0;
  int                trmt_cnt = 0;
  int                ram_mode = 0;
  int                ucnt = 0;

  always #5 clk = ~clk;

  la_dump_seq #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst), .dump_req(dump_req), .dump_ch(dump_ch),
    .trig_pos(trig_pos), .ram_ch(ram_ch), .ram_addr(ram_addr),
    .ram_rd_en(ram_rd_en), .ram_rdata(ram_rdata), .tx_data(tx_data),
    .trmt(trmt), .tx_done(tx_done), .busy(busy)
  );

  // capture RAM: data one cycle after the read strobe
  always @(posedge clk)
    if (ram_rd_en) ram_rdata <= (ram_mode == 1) ? 8'd1 : ram_addr[7:0];

  // UART_tx: tx_done TX_LAT cycles after trmt; unaffected by rst
  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (trmt && !rst) ucnt <= TX_LAT;
    else if (ucnt > 0) begin
      ucnt <= ucnt - 1;
      if (ucnt == 1) tx_done <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (trmt) begin
        trmt_cnt++;
        if (exp_byte.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_trmt: tx_data=%h, want no transmit", tx_data);
        end else chk("tx_data", 32'(tx_data), 32'(exp_byte.pop_front()));
      end
      if (ram_rd_en) begin
        if (exp_addr.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rd: ram_addr=%0d, want no read", ram_addr);
        end else chk("ram_addr", 32'(ram_addr), 32'(exp_addr.pop_front()));
      end
    end
  end

  task automatic push_dump(input int tp, input int mode, input bit with_sum);
    logic [7:0] s, d;
    s = 8'h00;
    for (int i = 0; i < ENTRIES; i++) begin
      int a;
      a = (tp + i) % ENTRIES;
      d = (mode == 1) ? 8'd1 : 8'(a);
      exp_addr.push_back(ADDR_W'(a));
      exp_byte.push_back(d);
      s = s + d;
    end
    if (with_sum && EXTRA == 1) exp_byte.push_back(s);
  endtask

  task automatic start(input logic [2:0] ch, input int tp);
    @(posedge clk); #1;
    dump_ch = ch; trig_pos = ADDR_W'(tp); dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < BUDGET);
    if (busy) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: busy=1 after %0d cycles, want 0", nm, n);
    end
  endtask

  task automatic wait_trmts(input int base, input int target);
    int n;
    n = 0;
    while ((trmt_cnt - base) < target && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if ((trmt_cnt - base) < target) begin
      n_cmp++; n_bad++;
      $display("FAIL trmt_wait_timeout: got %0d, want %0d", trmt_cnt - base, target);
    end
  endtask

  initial begin
    int base;
    rst = 1'b1; dump_req = 1'b0; dump_ch = 3'd0; trig_pos = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state after 10 idle cycles
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_ch", 32'(ram_ch), 0);
    chk("rst_rd_en", 32'(ram_rd_en), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_trmt", 32'(trmt), 0);
    chk("rst_busy", 32'(busy), 0);

    // full dump of channel 3 from trig_pos 100, with a repeated request mid-dump
    base = trmt_cnt;
    push_dump(100, 0, 1'b1);
    start(CH3, 100);
    @(negedge clk);
    chk("busy_after_req", 32'(busy), 1);
    chk("ram_ch_latched", 32'(ram_ch), 32'(CH3));
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("first_trmt_lat", 32'(trmt), 1);
    chk("first_byte", 32'(tx_data), 32'h64);
    wait_trmts(base, 10);
    start(CH5, 7);
    wait_idle("dump3");
    chk("dump3_count", 32'(trmt_cnt - base), 32'(ENTRIES + EXTRA));
    chk("dump3_ram_ch", 32'(ram_ch), 32'(CH3));

    // invalid channels: one NAK byte, no RAM reads
    base = trmt_cnt;
    exp_byte.push_back(8'hEE);
    start(3'd0, 0);
    wait_idle("nak0");
    chk("nak0_count", 32'(trmt_cnt - base), 1);
    repeat (5) @(posedge clk);
    base = trmt_cnt;
    exp_byte.push_back(8'hEE);
    start(3'd7, 0);
    wait_idle("nak7");
    chk("nak7_count", 32'(trmt_cnt - base), 1);
    repeat (5) @(posedge clk);

    // reset after the 50th byte, then a clean restart
    base = trmt_cnt;
    for (int i = 0; i < 50; i++) begin
      exp_addr.push_back(ADDR_W'((200 + i) % ENTRIES));
      exp_byte.push_back(8'((200 + i) % ENTRIES));
    end
    start(CH1, 200);
    wait_trmts(base, 50);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_trmt", 32'(trmt), 0);
    chk("midrst_rd_en", 32'(ram_rd_en), 0);
    repeat (40) @(posedge clk);
    chk("midrst_no_more", 32'(trmt_cnt - base), 50);
    base = trmt_cnt;
    push_dump(5, 0, 1'b1);
    start(CH2, 5);
    wait_idle("restart");
    chk("restart_count", 32'(trmt_cnt - base), 32'(ENTRIES + EXTRA));

`ifdef DUMP_CHKSUM_EN
    // all-ones RAM: checksum byte is 384 mod 256
    ram_mode = 1;
    base = trmt_cnt;
    push_dump(0, 1, 1'b0);
    exp_byte.push_back(8'h80);
    start(CH4, 0);
    wait_idle("chksum");
    chk("chksum_count", 32'(trmt_cnt - base), 32'(ENTRIES + 1));
`endif

    repeat (5) @(posedge clk);
    chk("bytes_left", 32'(exp_byte.size()), 0);
    chk("addrs_left", 32'(exp_addr.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
